vga_timing_gen: RTL and testbench

//  Parametrised VGA raster engine: timing, sync, blanking and pixel fetch for the miner status display.

---
 rtl/vga_timing_gen_pkg.sv | 30 +++
 rtl/vga_timing_gen_axis_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and elaboration helpers for the VGA raster engine.
package vga_timing_pkg;

    // 640x480 @ 60 Hz timing set (pixel ticks / lines)
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;

    // Full period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold 0..value-1, never less than 1 so ports stay legal.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned bits;
        bits = 1;
        while ((64'(1) << bits) < 64'(value)) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrap counter plus active-region and sync decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = VGA640_H_ACTIVE,
    parameter int unsigned FP       = VGA640_H_FP,
    parameter int unsigned SYNC     = VGA640_H_SYNC,
    parameter int unsigned BP       = VGA640_H_BP,
    parameter bit          SYNC_POL = 1'b0,
    localparam int unsigned TOTAL   = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int unsigned CNT_W   = clog2_min1(TOTAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
        $error("vga_axis_counter: active, porch and sync widths must all be >= 1");
    end

    assign wrap   = (cnt == CNT_W'(TOTAL - 1));
    assign active = (cnt < CNT_W'(ACTIVE));

    // Sync level decode from the current count
    always_comb begin
        sync = ~SYNC_POL;
        if (cnt >= CNT_W'(SYNC_START) && cnt < CNT_W'(SYNC_END)) begin
            sync = SYNC_POL;
        end
    end

    // Position counter, advances on enable and wraps at TOTAL-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: pixel-tick divider, h/v counters, framebuffer fetch and
// a two-tick output pipeline that keeps syncs and colour aligned at the pins.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FP     = VGA640_H_FP,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BP     = VGA640_H_BP,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FP     = VGA640_V_FP,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BP     = VGA640_V_BP,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned COLOR_W  = 1,
    parameter bit          SYNC_POL = 1'b0,
    localparam int unsigned X_W     = clog2_min1(H_ACTIVE),
    localparam int unsigned Y_W     = clog2_min1(V_ACTIVE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3*COLOR_W-1:0] pix_rgb,
    output logic                 pix_req,
    output logic [X_W-1:0]       pix_x,
    output logic [Y_W-1:0]       pix_y,
    output logic                 vga_h_sync,
    output logic                 vga_v_sync,
    output logic [COLOR_W-1:0]   vga_R,
    output logic [COLOR_W-1:0]   vga_G,
    output logic [COLOR_W-1:0]   vga_B,
    output logic                 frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HC_W    = clog2_min1(H_TOTAL);
    localparam int unsigned VC_W    = clog2_min1(V_TOTAL);
    localparam int unsigned DIV_W   = clog2_min1(CLK_DIV);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [HC_W-1:0]  h_cnt;
    logic [VC_W-1:0]  v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_active, v_active;
    logic             h_sync, v_sync;
    logic             at_origin;
    logic             s1_active, s1_h_sync, s1_v_sync, s1_first;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Pixel-tick divider, counts 0..CLK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick & h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    assign pix_req = tick & h_active & v_active;
    assign pix_x   = X_W'(h_cnt);
    assign pix_y   = Y_W'(v_cnt);

    // Stage 1: capture the decoded position state on each tick.
    // at_origin tracks "counters sit at (0,0)" from the wrap strobes so the
    // frame marker needs no separate full-width compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_origin <= 1'b1;
            s1_active <= 1'b0;
            s1_h_sync <= ~SYNC_POL;
            s1_v_sync <= ~SYNC_POL;
            s1_first  <= 1'b0;
        end else if (tick) begin
            at_origin <= h_wrap & v_wrap;
            s1_active <= h_active & v_active;
            s1_h_sync <= h_sync;
            s1_v_sync <= v_sync;
            s1_first  <= at_origin;
        end
    end

    // Stage 2: drive the pins; colour only from a fetched (active) pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_h_sync <= ~SYNC_POL;
            vga_v_sync <= ~SYNC_POL;
            vga_R      <= '0;
            vga_G      <= '0;
            vga_B      <= '0;
        end else if (tick) begin
            vga_h_sync <= s1_h_sync;
            vga_v_sync <= s1_v_sync;
            if (s1_active) begin
                vga_R <= pix_rgb[3*COLOR_W-1 -: COLOR_W];
                vga_G <= pix_rgb[2*COLOR_W-1 -: COLOR_W];
                vga_B <= pix_rgb[COLOR_W-1:0];
            end else begin
                vga_R <= '0;
                vga_G <= '0;
                vga_B <= '0;
            end
        end
    end

    // One-clk marker alongside the edge that puts pixel (0,0) on the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick & s1_first;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 8x6 raster at CLK_DIV=2 plus default 640x480 at CLK_DIV=1.
// Samples are taken on the falling edge; sample c is the c-th falling edge
// after rst_n is released (released on a falling edge).
module tb_vga_timing_gen;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] pix_rgb = '0;
    logic       pix_req;
    logic [1:0] pix_x, pix_y;
    logic       vga_h_sync, vga_v_sync;
    logic [1:0] vga_R, vga_G, vga_B;
    logic       frame_start;

    logic [2:0] d_rgb = 3'b101;
    logic       d_req;
    logic [9:0] d_x;
    logic [8:0] d_y;
    logic       d_hs, d_vs, d_R, d_G, d_B, d_fs;

    int n_checks = 0;
    int n_fail   = 0;
    bit x_mode   = 1'b0;
    int since_req = 0;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .COLOR_W(2), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_rgb(pix_rgb), .pix_req(pix_req),
        .pix_x(pix_x), .pix_y(pix_y), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B), .frame_start(frame_start)
    );

    vga_timing_gen #(
        .CLK_DIV(1)
    ) dut_vga (
        .clk(clk), .rst_n(rst_n), .pix_rgb(d_rgb), .pix_req(d_req),
        .pix_x(d_x), .pix_y(d_y), .vga_h_sync(d_hs), .vga_v_sync(d_vs),
        .vga_R(d_R), .vga_G(d_G), .vga_B(d_B), .frame_start(d_fs)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pat(input logic [1:0] x, input logic [1:0] y);
        return {x, y, x ^ y};
    endfunction

    // Sync-read framebuffer: data appears the edge after pix_req and is held;
    // in x_mode it turns to X once it can no longer be legally sampled.
    always @(posedge clk) begin
        if (pix_req) begin
            pix_rgb   <= pat(pix_x, pix_y);
            since_req <= 0;
        end else begin
            if (x_mode && since_req >= 1) pix_rgb <= 'x;
            since_req <= since_req + 1;
        end
    end

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (vga_h_sync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", vga_h_sync); end
        n_checks++; if (vga_v_sync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vga_v_sync); end
        n_checks++; if ({vga_R, vga_G, vga_B} !== 6'd0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 00", {vga_R, vga_G, vga_B}); end
        n_checks++; if (pix_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", pix_req); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (pix_req !== 1'b0) begin n_fail++; $display("FAIL release_req: got %b expected 0", pix_req); end
        // pix_req is high in the cycle that ends at the 2nd edge after release
        @(negedge clk);
        n_checks++; if (pix_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", pix_req); end
        n_checks++; if ({pix_x, pix_y} !== 4'd0) begin n_fail++; $display("FAIL first_xy: got x=%0d y=%0d expected 0,0", pix_x, pix_y); end
        @(negedge clk);
        n_checks++; if (pix_req !== 1'b0) begin n_fail++; $display("FAIL req_one_clk: got %b expected 0", pix_req); end
    endtask

    task automatic test_frame_counts();
        int reqs = 0, gaps2 = 0, last = -100, fs_n = 0, fs_first = -1, fs_second = -1;
        apply_reset(2);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (pix_req && c <= 96) begin
                reqs++;
                if (c - last == 2) gaps2++;
                last = c;
            end
            if (frame_start) begin
                fs_n++;
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
        end
        n_checks++; if (reqs != 12) begin n_fail++; $display("FAIL req_count: got %0d expected 12", reqs); end
        n_checks++; if (gaps2 != 9) begin n_fail++; $display("FAIL req_spacing: got %0d two-clk gaps expected 9", gaps2); end
        n_checks++; if (fs_first != 4) begin n_fail++; $display("FAIL fs_first: got sample %0d expected 4", fs_first); end
        n_checks++; if (fs_second - fs_first != 96) begin n_fail++; $display("FAIL frame_period: got %0d expected 96", fs_second - fs_first); end
        n_checks++; if (fs_n != 3) begin n_fail++; $display("FAIL fs_pulses: got %0d high samples expected 3", fs_n); end
    endtask

    task automatic test_pixel_pipeline();
        bit   found = 1'b0;
        bit   hv[5];
        logic [1:0] hx[5], hy[5];
        int   kk, line, h;
        logic [5:0] exp_rgb;
        for (int i = 0; i < 5; i++) begin hv[i] = 1'b0; hx[i] = '0; hy[i] = '0; end
        apply_reset(2);
        x_mode = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL pipe_wait_fs: got no frame_start expected one within 200 clk"); end
        for (int k = 0; k < 192 && found; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 4; i > 0; i--) begin hv[i] = hv[i-1]; hx[i] = hx[i-1]; hy[i] = hy[i-1]; end
            hv[0] = pix_req; hx[0] = pix_x; hy[0] = pix_y;
            kk = k % 96; line = kk / 16; h = (kk % 16) / 2;
            exp_rgb = (h < 4 && line < 3) ? pat(2'(h), 2'(line)) : 6'd0;
            n_checks++; if ({vga_R, vga_G, vga_B} !== exp_rgb) begin n_fail++; $display("FAIL pipe_rgb k=%0d: got %h expected %h", k, {vga_R, vga_G, vga_B}, exp_rgb); end
            n_checks++; if ($isunknown({vga_R, vga_G, vga_B, vga_h_sync, vga_v_sync, frame_start})) begin n_fail++; $display("FAIL pins_x k=%0d: got %b expected no X", k, {vga_R, vga_G, vga_B, vga_h_sync, vga_v_sync}); end
            if (hv[3]) begin
                n_checks++; if ({vga_R, vga_G, vga_B} !== pat(hx[3], hy[3])) begin n_fail++; $display("FAIL req_latency3 k=%0d: got %h expected %h", k, {vga_R, vga_G, vga_B}, pat(hx[3], hy[3])); end
            end
            if (hv[4]) begin
                n_checks++; if ({vga_R, vga_G, vga_B} !== pat(hx[4], hy[4])) begin n_fail++; $display("FAIL req_latency4 k=%0d: got %h expected %h", k, {vga_R, vga_G, vga_B}, pat(hx[4], hy[4])); end
            end
        end
        x_mode = 1'b0;
    endtask

    task automatic test_sync_timing();
        bit found = 1'b0;
        int kk, line, h, hs_low = 0, vs_low = 0;
        logic exp_hs, exp_vs, exp_fs;
        apply_reset(2);
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL sync_wait_fs: got no frame_start expected one within 200 clk"); end
        for (int k = 0; k < 96 && found; k++) begin
            if (k > 0) @(negedge clk);
            kk = k; line = kk / 16; h = (kk % 16) / 2;
            exp_hs = (h == 5 || h == 6) ? 1'b0 : 1'b1;
            exp_vs = (line == 4) ? 1'b0 : 1'b1;
            exp_fs = (k == 0) ? 1'b1 : 1'b0;
            if (vga_h_sync === 1'b0) hs_low++;
            if (vga_v_sync === 1'b0) vs_low++;
            n_checks++; if (vga_h_sync !== exp_hs) begin n_fail++; $display("FAIL hsync k=%0d: got %b expected %b", k, vga_h_sync, exp_hs); end
            n_checks++; if (vga_v_sync !== exp_vs) begin n_fail++; $display("FAIL vsync k=%0d: got %b expected %b", k, vga_v_sync, exp_vs); end
            n_checks++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL fs_shape k=%0d: got %b expected %b", k, frame_start, exp_fs); end
        end
        n_checks++; if (hs_low != 24) begin n_fail++; $display("FAIL hsync_low_total: got %0d expected 24", hs_low); end
        n_checks++; if (vs_low != 16) begin n_fail++; $display("FAIL vsync_low_total: got %0d expected 16", vs_low); end
    endtask

    task automatic test_mid_line_reset();
        bit found = 1'b0;
        int fs_n = 0, fs_first = -1, fs_second = -1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL mid_wait_fs: got no frame_start expected one within 200 clk"); end
        // k=35: line 2, pixel x=1 on the pins
        repeat (35) @(negedge clk);
        n_checks++; if ({vga_R, vga_G, vga_B} !== 6'b011011) begin n_fail++; $display("FAIL mid_pre_rgb: got %h expected 1b", {vga_R, vga_G, vga_B}); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({vga_R, vga_G, vga_B} !== 6'd0) begin n_fail++; $display("FAIL mid_async_rgb: got %h expected 00", {vga_R, vga_G, vga_B}); end
        n_checks++; if ({vga_h_sync, vga_v_sync} !== 2'b11) begin n_fail++; $display("FAIL mid_async_sync: got %b expected 11", {vga_h_sync, vga_v_sync}); end
        n_checks++; if ({pix_req, frame_start} !== 2'b00) begin n_fail++; $display("FAIL mid_async_req_fs: got %b expected 00", {pix_req, frame_start}); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c < 4) begin
                n_checks++; if ({vga_R, vga_G, vga_B} !== 6'd0) begin n_fail++; $display("FAIL mid_no_partial c=%0d: got %h expected 00", c, {vga_R, vga_G, vga_B}); end
            end
            if (frame_start) begin
                fs_n++;
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
        end
        n_checks++; if (fs_first != 4) begin n_fail++; $display("FAIL mid_fs_first: got %0d expected 4", fs_first); end
        n_checks++; if (fs_second != 100) begin n_fail++; $display("FAIL mid_fs_next: got %0d expected 100", fs_second); end
        n_checks++; if (fs_n != 2) begin n_fail++; $display("FAIL mid_fs_count: got %0d expected 2", fs_n); end
    endtask

    task automatic test_default_hsync();
        int t1 = -1, t2 = -1, rise = -1;
        logic prev = 1'b1;
        logic vs_at_fall = 1'b0;
        for (int c = 0; c < 3000 && t2 < 0; c++) begin
            @(negedge clk);
            if (prev === 1'b1 && d_hs === 1'b0) begin
                if (t1 < 0) begin t1 = c; vs_at_fall = d_vs; end
                else t2 = c;
            end
            if (prev === 1'b0 && d_hs === 1'b1 && t1 >= 0 && rise < 0) rise = c;
            prev = d_hs;
        end
        n_checks++; if (t2 < 0) begin n_fail++; $display("FAIL def_hsync_seen: got %0d falls expected 2 within 3000 clk", (t1 >= 0) ? 1 : 0); end
        n_checks++; if (t2 - t1 != 800) begin n_fail++; $display("FAIL def_hsync_period: got %0d expected 800", t2 - t1); end
        n_checks++; if (rise - t1 != 96) begin n_fail++; $display("FAIL def_hsync_low: got %0d expected 96", rise - t1); end
        n_checks++; if (vs_at_fall !== 1'b1) begin n_fail++; $display("FAIL def_vsync_idle: got %b expected 1", vs_at_fall); end
    endtask

    initial begin
        test_reset();
        test_frame_counts();
        test_pixel_pipeline();
        test_sync_timing();
        test_mid_line_reset();
        test_default_hsync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
